// File: rtl/y_enhance_stat_if.sv
// rtl/y_enhance_stat_if.sv - tapped 24-bit YCbCr video stream bundle
// Purpose: groups the monitored video link signals so the stats unit can tap them.
// Signals:
//   data  [23:0] {Y,Cb,Cr} beat data
//   valid        beat valid
//   sop          start of frame
//   eop          end of frame
//   ready        link ready as seen on the wire
// Modports:
//   master drives every signal (the link source / bench)
//   slave  observes every signal (passive tap)
interface y_enhance_stat_if;
  logic [23:0] data;
  logic        valid;
  logic        sop;
  logic        eop;
  logic        ready;

  modport master (output data, valid, sop, eop, ready);
  modport slave  (input  data, valid, sop, eop, ready);
endinterface

// File: rtl/y_enhance_stat.sv
// rtl/y_enhance_stat.sv - passive per-frame Y min/max statistics and 8.8 gain divider
// Purpose: tracks min/max luma over each accepted frame and, at end of frame,
//   computes rate = floor(OUT_MAX*256/(max-min)) with a 16-step restoring divider.
// Ports:
//   clk         clock
//   rst_n       asynchronous reset, active low
//   video_in    tapped stream (slave modport, monitored only)
//   enable      0: ignore all beats, no new results
//   rate        8.8 gain for the next frame
//   min_value   black level for the next frame
//   diff2small  frame range below DIFF_MIN
//   stat_valid  one-cycle pulse when the outputs update
//   busy        divider running
module y_enhance_stat #(
  parameter int          DIFF_MIN   = 16,
  parameter int          OUT_MAX    = 255,
  parameter logic [15:0] UNITY_RATE = 16'h0100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  y_enhance_stat_if.slave         video_in,
  input  logic                    enable,
  output logic [15:0]             rate,
  output logic [7:0]              min_value,
  output logic                    diff2small,
  output logic                    stat_valid,
  output logic                    busy
);

  localparam logic [15:0] DIVIDEND = 16'(OUT_MAX * 256);
  localparam logic [7:0]  DMIN     = 8'(DIFF_MIN);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state;

  logic [7:0]  y;
  logic        acc;
  logic        end_frame;
  logic [7:0]  frame_min;
  logic [7:0]  frame_max;

  logic        in_frame;
  logic [7:0]  run_min;
  logic [7:0]  run_max;

  logic        pend_valid;
  logic [7:0]  pend_min;
  logic [7:0]  pend_max;

  logic        load;
  logic [7:0]  ld_min;
  logic [7:0]  ld_max;

  logic [7:0]  range_r;
  logic [7:0]  fmin_r;
  logic [15:0] quo;
  logic [7:0]  rem;
  logic [3:0]  cnt;
  logic [8:0]  rem_sh;
  logic [8:0]  rem_sub;
  logic        take;

  always_comb begin
    y   = video_in.data[23:16];
    acc = video_in.valid & video_in.ready & enable;
    // A sop beat restarts the running extremes with its own Y, so the
    // current beat is always folded in, including the eop beat.
    if (video_in.sop) begin
      frame_min = y;
      frame_max = y;
    end else begin
      frame_min = (y < run_min) ? y : run_min;
      frame_max = (y > run_max) ? y : run_max;
    end
    end_frame = acc & video_in.eop & (video_in.sop | in_frame);

    // A fresh eop wins over a queued one: the pending slot only keeps the newest frame.
    ld_min = end_frame ? frame_min : pend_min;
    ld_max = end_frame ? frame_max : pend_max;
    // The engine accepts a new frame in IDLE or on the DONE edge itself, so
    // back-to-back results stay exactly 17 edges apart.
    load   = ((state == IDLE) || (state == DONE)) && (end_frame || pend_valid);

    rem_sh  = {rem, quo[15]};
    rem_sub = rem_sh - {1'b0, range_r};
    take    = (rem_sh >= {1'b0, range_r});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame <= 1'b0;
      run_min  <= 8'd0;
      run_max  <= 8'd0;
    end else if (acc && (video_in.sop || in_frame)) begin
      run_min  <= frame_min;
      run_max  <= frame_max;
      in_frame <= ~video_in.eop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rate       <= UNITY_RATE;
      min_value  <= 8'd0;
      diff2small <= 1'b0;
      stat_valid <= 1'b0;
      busy       <= 1'b0;
      pend_valid <= 1'b0;
      pend_min   <= 8'd0;
      pend_max   <= 8'd0;
      range_r    <= 8'd0;
      fmin_r     <= 8'd0;
      quo        <= 16'd0;
      rem        <= 8'd0;
      cnt        <= 4'd0;
    end else begin
      stat_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            range_r    <= ld_max - ld_min;
            fmin_r     <= ld_min;
            quo        <= DIVIDEND;
            rem        <= 8'd0;
            cnt        <= 4'd0;
            busy       <= 1'b1;
            pend_valid <= 1'b0;
            state      <= DIV;
          end
        end
        DIV: begin
          // quo shifts dividend bits out of the top and quotient bits in at the bottom.
          // The remainder stays below the divisor, so 8 bits suffice after subtract.
          rem <= take ? rem_sub[7:0] : rem_sh[7:0];
          quo <= {quo[14:0], take};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            busy  <= 1'b0;
            state <= DONE;
          end
          if (end_frame) begin
            pend_valid <= 1'b1;
            pend_min   <= frame_min;
            pend_max   <= frame_max;
          end
        end
        DONE: begin
          if (range_r >= DMIN) begin
            rate       <= quo;
            min_value  <= fmin_r;
            diff2small <= 1'b0;
          end else begin
            rate       <= UNITY_RATE;
            min_value  <= 8'd0;
            diff2small <= 1'b1;
          end
          stat_valid <= 1'b1;
          if (load) begin
            range_r    <= ld_max - ld_min;
            fmin_r     <= ld_min;
            quo        <= DIVIDEND;
            rem        <= 8'd0;
            cnt        <= 4'd0;
            busy       <= 1'b1;
            pend_valid <= 1'b0;
            state      <= DIV;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y_enhance_stat.sv
// tb/tb_y_enhance_stat.sv - scoreboard bench for y_enhance_stat
module tb_y_enhance_stat;

  typedef struct {
    logic [15:0] rate;
    logic [7:0]  minv;
    logic        d2s;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] rate;
  logic [7:0]  min_value;
  logic        diff2small;
  logic        stat_valid;
  logic        busy;

  y_enhance_stat_if vif ();

  y_enhance_stat dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .video_in   (vif.slave),
    .enable     (enable),
    .rate       (rate),
    .min_value  (min_value),
    .diff2small (diff2small),
    .stat_valid (stat_valid),
    .busy       (busy)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   prev_start = -100;
  int   last_pulse = -1000;
  int   prev_pulse = -1000;
  int   pulses = 0;
  exp_t exp_q[$];
  int   edge_q[$];
  exp_t e;
  int   ee;
  int   s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic exp_t model(input logic [7:0] mn, input logic [7:0] mx);
    exp_t r;
    int   span;
    span = int'(mx) - int'(mn);
    if (span < 16) begin
      r.rate = 16'h0100;
      r.minv = 8'd0;
      r.d2s  = 1'b1;
    end else begin
      r.rate = 16'(65280 / span);
      r.minv = mn;
      r.d2s  = 1'b0;
    end
    return r;
  endfunction

  // Monitor: predicts the result edge for each accepted eop and checks every stat_valid pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      edge_q.delete();
      prev_start = -100;
    end else begin
      if (vif.valid && vif.ready && enable && vif.eop) begin
        s = (cyc + 1 > prev_start + 17) ? cyc + 1 : prev_start + 17;
        prev_start = s;
        edge_q.push_back(s + 17);
      end
      if (stat_valid) begin
        pulses++;
        prev_pulse = last_pulse;
        last_pulse = cyc;
        checks++;
        assert (exp_q.size() != 0 && edge_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_stat_valid: got pulse at cycle %0d expected none", cyc);
        end
        if (exp_q.size() != 0 && edge_q.size() != 0) begin
          e  = exp_q.pop_front();
          ee = edge_q.pop_front();
          checks++;
          assert (rate === e.rate) else begin
            errors++;
            $error("FAIL rate: got %h expected %h", rate, e.rate);
          end
          checks++;
          assert (min_value === e.minv) else begin
            errors++;
            $error("FAIL min_value: got %0d expected %0d", min_value, e.minv);
          end
          checks++;
          assert (diff2small === e.d2s) else begin
            errors++;
            $error("FAIL diff2small: got %b expected %b", diff2small, e.d2s);
          end
          checks++;
          assert (cyc === ee) else begin
            errors++;
            $error("FAIL latency: got edge %0d expected edge %0d", cyc, ee);
          end
        end
      end
    end
  end

  task automatic drive_beat(input logic [7:0] yv, input logic sp, input logic ep, input logic rd);
    @(posedge clk);
    #1;
    vif.data  = {yv, 16'h8080};
    vif.valid = 1'b1;
    vif.sop   = sp;
    vif.eop   = ep;
    vif.ready = rd;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    vif.valid = 1'b0;
    vif.sop   = 1'b0;
    vif.eop   = 1'b0;
    vif.ready = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] px[$], input bit expect_result);
    logic [7:0] mn;
    logic [7:0] mx;
    mn = px[0];
    mx = px[0];
    foreach (px[i]) begin
      if (px[i] < mn) mn = px[i];
      if (px[i] > mx) mx = px[i];
    end
    if (expect_result) exp_q.push_back(model(mn, mx));
    foreach (px[i]) drive_beat(px[i], i == 0, i == px.size() - 1, 1'b1);
    idle();
  endtask

  task automatic wait_results(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 200)) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s_timeout: got %0d outstanding results expected 0", tag, exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert (rate === 16'h0100) else begin
      errors++; $error("FAIL %s_rate: got %h expected 0100", tag, rate);
    end
    checks++;
    assert (min_value === 8'd0) else begin
      errors++; $error("FAIL %s_min: got %0d expected 0", tag, min_value);
    end
    checks++;
    assert (diff2small === 1'b0) else begin
      errors++; $error("FAIL %s_d2s: got %b expected 0", tag, diff2small);
    end
    checks++;
    assert (stat_valid === 1'b0) else begin
      errors++; $error("FAIL %s_stat_valid: got %b expected 0", tag, stat_valid);
    end
    checks++;
    assert (busy === 1'b0) else begin
      errors++; $error("FAIL %s_busy: got %b expected 0", tag, busy);
    end
  endtask

  initial begin
    logic [7:0] px[$];
    int         p0;

    rst_n     = 1'b0;
    enable    = 1'b1;
    vif.data  = 24'h0;
    vif.valid = 1'b0;
    vif.sop   = 1'b0;
    vif.eop   = 1'b0;
    vif.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check_reset_outputs("after_reset");
    checks++;
    assert (pulses === 0) else begin
      errors++; $error("FAIL idle_pulses: got %0d expected 0", pulses);
    end

    // 64-pixel ramp 16..235
    px.delete();
    for (int i = 0; i < 64; i++) px.push_back(8'(16 + (219 * i) / 63));
    send_frame(px, 1'b1);
    wait_results("ramp");

    // Narrow range, then full range
    px = '{100, 105, 110, 102, 108, 101};
    send_frame(px, 1'b1);
    wait_results("narrow");
    px = '{128, 0, 255, 64};
    send_frame(px, 1'b1);
    wait_results("full");

    // DIFF_MIN boundary, one below it, and a one-pixel frame
    px = '{40, 56};
    send_frame(px, 1'b1);
    wait_results("range16");
    px = '{40, 55};
    send_frame(px, 1'b1);
    wait_results("range15");
    px = '{77};
    send_frame(px, 1'b1);
    wait_results("one_pixel");

    // Frame while disabled produces nothing; outputs hold the previous result
    enable = 1'b0;
    px = '{10, 200, 30};
    send_frame(px, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    enable = 1'b1;
    checks++;
    assert (diff2small === 1'b1 && rate === 16'h0100) else begin
      errors++; $error("FAIL disabled_hold: got d2s=%b rate=%h expected d2s=1 rate=0100", diff2small, rate);
    end

    // Stalled beat (ready low) with Y=0 must not count
    exp_q.push_back(model(8'd50, 8'd200));
    drive_beat(8'd100, 1'b1, 1'b0, 1'b1);
    repeat (3) drive_beat(8'd0, 1'b0, 1'b0, 1'b0);
    idle();
    for (int yv = 50; yv <= 200; yv += 30) drive_beat(8'(yv), 1'b0, yv == 200, 1'b1);
    idle();
    wait_results("stall");

    // Back-to-back 4-pixel frames: second eop lands during the division
    p0 = pulses;
    px = '{10, 90, 40, 60};
    send_frame(px, 1'b1);
    px = '{20, 20, 200, 120};
    send_frame(px, 1'b1);
    wait_results("b2b");
    checks++;
    assert ((pulses - p0) === 2 && (last_pulse - prev_pulse) === 17) else begin
      errors++;
      $error("FAIL b2b_spacing: got %0d pulses gap %0d expected 2 pulses gap 17", pulses - p0, last_pulse - prev_pulse);
    end

    // Reset at E8 of a division
    p0 = pulses;
    px = '{30, 90, 150};
    send_frame(px, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    checks++;
    assert (busy === 1'b1) else begin
      errors++; $error("FAIL busy_mid_div: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_div_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    assert (pulses === p0) else begin
      errors++; $error("FAIL reset_no_pulse: got %0d pulses expected %0d", pulses, p0);
    end
    px = '{60, 180, 90, 120};
    send_frame(px, 1'b1);
    wait_results("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
